// File: rtl/trans_pkg.sv
// Shared types for the transactor dispatcher.
// Holds the FSM encoding and the round-robin pick helper.
package trans_pkg;

  localparam int OP_W_DEF = 11;
  localparam int MAX_REQ  = 16;
  localparam int IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit at or above ptr, wrapping at n.
  function automatic pick_t rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   ptr,
    input int                 n
  );
    pick_t p;
    int    j;
    p = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        j = int'(ptr) + i;
        if (j >= n) j = j - n;
        if (!p.valid && req[j]) begin
          p.valid = 1'b1;
          p.idx   = IDX_W'(j);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/trans_dispatcher_rr_arbiter.sv
// Combinational round-robin pick.
// The priority pointer is owned by the caller.
module rr_arbiter
  import trans_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  pick_t pick;

  // Search upward from ptr for the next requestor.
  always_comb begin
    pick = rr_pick(MAX_REQ'(req), ptr, NUM_REQ);
  end

  assign valid = pick.valid;
  assign idx   = pick.idx;

endmodule

// File: rtl/trans_dispatcher.sv
// Round-robin dispatcher in front of one transactor.
// Issues one op, waits for work_done rise, acks winner.
module trans_dispatcher
  import trans_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OP_W    = OP_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*OP_W-1:0] req_op,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    do_work,
  output logic [OP_W-1:0]         op_code,
  input  logic                    work_done,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [31:0]             issue_count
);

  localparam int TMR_W =
    (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'(TIMEOUT - 2);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_REQ - 1);

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [TMR_W-1:0] timer;
  logic             wd_q;
  logic             rise;
  logic             expire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign rise   = work_done & ~wd_q;
  assign expire = (timer == TMR_LAST) & ~rise;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and Moore outputs.
  always_comb begin
    next_state = state;
    ack        = '0;
    do_work    = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE:  if (pick_valid) next_state = ISSUE;
      ISSUE: begin
        do_work    = 1'b1;
        next_state = WAIT;
      end
      WAIT:  if (rise || expire) next_state = DONE;
      DONE:  begin
        next_state = IDLE;
        for (int i = 0; i < NUM_REQ; i++)
          ack[i] = (grant == IDX_W'(i));
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: grant latch, timer, counters, flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q        <= 1'b0;
      rr_ptr      <= '0;
      grant       <= '0;
      op_code     <= '0;
      timer       <= '0;
      timeout_err <= 1'b0;
      issue_count <= '0;
    end else begin
      wd_q <= work_done;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            grant   <= pick_idx;
            op_code <=
              req_op[int'(pick_idx)*OP_W +: OP_W];
          end
        end
        ISSUE: begin
          issue_count <= issue_count + 32'd1;
          timer       <= '0;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (expire) timeout_err <= 1'b1;
        end
        DONE: begin
          if (grant == LAST_IDX) rr_ptr <= '0;
          else rr_ptr <= grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trans_dispatcher.sv
// Directed bench for trans_dispatcher.
// Hand-computed expectations, immediate assertions.
module tb_trans_dispatcher;

  localparam int NR = 4;
  localparam int OW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [NR*OW-1:0] req_op;
  logic [NR-1:0] ack;
  logic          do_work;
  logic [OW-1:0] op_code;
  logic          work_done;
  logic          busy;
  logic          timeout_err;
  logic [31:0]   issue_count;

  int n_cmp = 0;
  int n_err = 0;

  trans_dispatcher #(
    .NUM_REQ (NR),
    .OP_W    (OW),
    .TIMEOUT (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_op      (req_op),
    .ack         (ack),
    .do_work     (do_work),
    .op_code     (op_code),
    .work_done   (work_done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .issue_count (issue_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    work_done = 1'b0;
    tick();
    tick();
    chk("rst_ack",   64'(ack), 0);
    chk("rst_dowork", 64'(do_work), 0);
    chk("rst_op",    64'(op_code), 0);
    chk("rst_busy",  64'(busy), 0);
    chk("rst_err",   64'(timeout_err), 0);
    chk("rst_cnt",   64'(issue_count), 0);
    reset = 1'b0;
  endtask

  // Starts in IDLE with req already driven.
  // Rise lands dly cycles after the do_work cycle.
  task automatic run_txn(
    input int          idx,
    input logic [10:0] op,
    input int          dly,
    input logic [3:0]  req_after
  );
    logic [3:0] one;
    one = 4'b0001 << idx;
    chk("pre_dowork", 64'(do_work), 0);
    tick();
    chk("dowork", 64'(do_work), 1);
    chk("opcode", 64'(op_code), 64'(op));
    chk("busy_issue", 64'(busy), 1);
    tick();
    chk("dowork_once", 64'(do_work), 0);
    repeat (dly - 1) tick();
    chk("no_early_ack", 64'(ack), 0);
    work_done = 1'b1;
    tick();
    chk("ack", 64'(ack), 64'(one));
    req       = req_after;
    work_done = 1'b0;
    tick();
    chk("ack_clear", 64'(ack), 0);
    chk("idle_busy", 64'(busy), 0);
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_op    = '0;
    work_done = 1'b0;
    do_reset();

    // single requestor, rise 3 cycles after do_work
    req_op = {11'd0, 11'd0, 11'd0, 11'h005};
    req    = 4'b0001;
    run_txn(0, 11'h005, 3, 4'b0000);
    chk("cnt_1", 64'(issue_count), 1);

    // all requesting: rotation 0..3 twice
    do_reset();
    req_op = {11'd13, 11'd12, 11'd11, 11'd10};
    req    = 4'b1111;
    for (int i = 0; i < 8; i++)
      run_txn(i % 4, 11'(10 + i % 4), 2, 4'b1111);
    chk("cnt_8", 64'(issue_count), 8);

    // work_done never rises: timeout
    req = 4'b0001;
    tick();
    chk("to_dowork", 64'(do_work), 1);
    tick();
    repeat (62) tick();
    chk("to_err_63", 64'(timeout_err), 0);
    chk("to_ack_63", 64'(ack), 0);
    tick();
    chk("to_err_64", 64'(timeout_err), 1);
    chk("to_ack", 64'(ack), 64'(4'b0001));
    req = 4'b0010;
    tick();
    run_txn(1, 11'd11, 2, 4'b0000);
    chk("to_sticky", 64'(timeout_err), 1);

    // rise exactly on the timeout cycle
    do_reset();
    req = 4'b0001;
    run_txn(0, 11'd10, 63, 4'b0000);
    chk("edge_err", 64'(timeout_err), 0);

    // rise during ISSUE is stale: times out
    req = 4'b0010;
    tick();
    chk("st_dowork", 64'(do_work), 1);
    work_done = 1'b1;
    tick();
    repeat (62) tick();
    chk("st_err_63", 64'(timeout_err), 0);
    tick();
    chk("st_err", 64'(timeout_err), 1);
    chk("st_ack", 64'(ack), 64'(4'b0010));
    req       = 4'b0000;
    work_done = 1'b0;
    tick();

    // move pointer to 3, then reset mid-WAIT
    req = 4'b0100;
    run_txn(2, 11'd12, 2, 4'b0100);
    tick();
    tick();
    tick();
    chk("mw_busy", 64'(busy), 1);
    reset = 1'b1;
    tick();
    chk("mw_ack",  64'(ack), 0);
    chk("mw_busy0", 64'(busy), 0);
    chk("mw_op",   64'(op_code), 0);
    chk("mw_err",  64'(timeout_err), 0);
    chk("mw_cnt",  64'(issue_count), 0);
    reset = 1'b0;
    req   = 4'b1010;
    run_txn(1, 11'd11, 2, 4'b0000);
    chk("mw_cnt1", 64'(issue_count), 1);

    // counter wrap
    force dut.issue_count = 32'hFFFF_FFFF;
    #1;
    release dut.issue_count;
    #1;
    chk("wr_pre", 64'(issue_count), 64'h0_FFFF_FFFF);
    req = 4'b0001;
    run_txn(0, 11'd10, 2, 4'b0000);
    chk("wr_cnt", 64'(issue_count), 0);
    chk("wr_err", 64'(timeout_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trans_dispatcher.md
Name: trans_dispatcher

Overview:
- Upstream stage feeding one transactor's do_work/op_code/work_done handshake.
- Arbitrates NUM_REQ independent requestors (test threads contending for one transactor) with round-robin priority.
- Issues one op_code at a time, waits for the transactor's work_done rising edge, then acknowledges the winning requestor.
- Counts issued operations and flags transactors that never complete.

Parameters:
- NUM_REQ, 4, number of requestors (2..16)
- OP_W, 11, op_code width (matches the 2048-task op space)
- TIMEOUT, 64, clk cycles to wait for work_done before declaring an error (>=2)

Ports:
- clk  input  1  single clock
- reset  input  1  synchronous, active-high
- req  input  NUM_REQ  per-requestor request level; held until ack
- req_op  input  NUM_REQ*OP_W  packed op_codes; slice i belongs to req[i]
- ack  output  NUM_REQ  one-cycle, one-hot completion pulse to the granted requestor
- do_work  output  1  one-cycle pulse starting a transaction
- op_code  output  OP_W  op for the current transaction; stable from the ISSUE cycle until DONE
- work_done  input  1  transactor completion level; its rising edge ends the transaction
- busy  output  1  high in ISSUE, WAIT and DONE
- timeout_err  output  1  sticky; set on timeout, cleared only by reset
- issue_count  output  32  total do_work pulses issued; wraps modulo 2^32

Behaviour:
- Reset (sync, active-high, overrides everything):
  - Outputs: ack=0, do_work=0, op_code=0, busy=0, timeout_err=0, issue_count=0.
  - State: FSM=IDLE, rr pointer=0, work_done_q=0, timer=0.
- Edge detect: work_done_q registers work_done every cycle; rise = work_done & ~work_done_q.
- FSM states:
  - IDLE: if any req, pick the first set bit searching from rr pointer upward (wrapping) and latch grant index g and op_code=req_op[g]. Go to ISSUE. No req means stay in IDLE.
  - ISSUE: do_work=1 for exactly this cycle; issue_count++; timer=0; go to WAIT.
  - WAIT: timer increments each cycle.
    - rise seen: go to DONE.
    - timer reaches TIMEOUT-1 with no rise: set timeout_err, go to DONE (ack still given so the requestor does not hang).
    - A rise in the same cycle as the timeout threshold counts as success; timeout_err is not set.
    - A rise during the ISSUE cycle is ignored (stale completion).
  - DONE: ack[g]=1 for one cycle; rr pointer=(g+1) mod NUM_REQ; go to IDLE.
- Latency:
  - req to do_work: 2 cycles (latched in IDLE, pulsed in ISSUE).
  - work_done rise to ack: 1 cycle (rise seen in WAIT, ack in DONE).
  - Minimum back-to-back: one IDLE cycle between ack and the next grant.
- Handshake rules:
  - A requestor must hold req and req_op until its ack. Dropping req mid-transaction does not abort it.
  - A requestor may reassert req in the cycle after its ack. It is then lowest priority if others are waiting.
- Boundaries:
  - All req high: grants rotate 0,1,2,3,0,...
  - Single requestor: granted every transaction.
  - issue_count wraps 0xFFFFFFFF to 0 without a flag.
  - work_done held high entering WAIT produces no rise, so the transaction times out.
  - Reset mid-WAIT: no ack is produced; the pending requestor must re-request.

Decomposition:
- Shared package trans_pkg:
  - OP_W default constant
  - FSM state enum {IDLE, ISSUE, WAIT, DONE}
  - function rr_pick(req, ptr) returning index and valid
- One sub-module, rr_arbiter: combinational round-robin pick from req and pointer. The pointer register lives in trans_dispatcher.

Test Plan:
- Single req[0], req_op[10:0]=11'h005, work_done rises 3 cycles after do_work:
  - do_work pulses once with op_code=5, 2 cycles after req.
  - ack=4'b0001 one cycle after the rise.
  - issue_count=1.
- req=4'b1111, ops 10,11,12,13, 8 transactions, each completing normally:
  - Grant/op order 10,11,12,13,10,11,12,13.
  - ack one-hot each time; issue_count=8.
- work_done never rises, TIMEOUT=64:
  - timeout_err=1 exactly 64 cycles after the do_work cycle.
  - ack still pulses; next request still served; timeout_err stays 1.
- work_done rise on the exact timeout cycle:
  - timeout_err stays 0; ack given.
- Reset asserted during WAIT:
  - All outputs return to reset values on the next edge; no ack; rr pointer=0.
  - After reset, req=4'b1010 grants index 1 first.
- issue_count preloaded near wrap via force to 0xFFFFFFFF, then one transaction:
  - issue_count=0; no other side effect.
